// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access unit with stall, timeout and load extension
module mem_access_unit #(
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        trap_in,
    input  logic [31:0] addr_aligned,
    input  logic [1:0]  bit_shift,
    input  logic [2:0]  funct3,
    input  logic [3:0]  wmask,
    input  logic [3:0]  rmask,
    input  logic [31:0] write_data,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        mem_err,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_funct3;
    logic [1:0]       r_shift;
    logic [3:0]       r_rmask;
    logic             r_dmem_read;
    logic             r_dmem_write;
    logic [31:0]      r_dmem_addr;
    logic [3:0]       r_dmem_wmask;
    logic [31:0]      r_dmem_wdata;
    logic [31:0]      r_load_data;
    logic             r_mem_err;
    logic             r_done;

    logic             w_mem_req;
    logic             w_timeout;
    logic             w_stall;
    logic [31:0]      w_rmask32;
    logic [31:0]      w_shifted;
    logic [31:0]      w_ext;

    assign w_mem_req = req_valid & (is_load | is_store) & ~trap_in;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST) && !dmem_resp;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_req) begin
                    w_stall = 1'b1;
                    w_next  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_stall = 1'b1;
                if (dmem_resp || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bytes outside the latched read mask are cleared before alignment.
    assign w_rmask32 = {{8{r_rmask[3]}}, {8{r_rmask[2]}}, {8{r_rmask[1]}}, {8{r_rmask[0]}}};
    assign w_shifted = (dmem_rdata & w_rmask32) >> {r_shift, 3'b000};

    always_comb begin
        w_ext = 32'd0;
        case (r_funct3)
            3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_ext = {24'd0, w_shifted[7:0]};
            3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_ext = {16'd0, w_shifted[15:0]};
            3'b010:  w_ext = w_shifted;
            default: w_ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_funct3     <= 3'd0;
            r_shift      <= 2'd0;
            r_rmask      <= 4'd0;
            r_dmem_read  <= 1'b0;
            r_dmem_write <= 1'b0;
            r_dmem_addr  <= 32'd0;
            r_dmem_wmask <= 4'd0;
            r_dmem_wdata <= 32'd0;
            r_load_data  <= 32'd0;
            r_mem_err    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_mem_req) begin
                        r_dmem_addr  <= addr_aligned;
                        r_dmem_read  <= is_load;
                        r_dmem_write <= is_store;
                        r_dmem_wmask <= is_store ? wmask : 4'd0;
                        r_dmem_wdata <= write_data << {bit_shift, 3'b000};
                        r_funct3     <= funct3;
                        r_shift      <= bit_shift;
                        r_rmask      <= rmask;
                        r_cnt        <= '0;
                        r_mem_err    <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    if (dmem_resp) begin
                        r_dmem_read  <= 1'b0;
                        r_dmem_write <= 1'b0;
                        r_mem_err    <= 1'b0;
                        r_done       <= 1'b1;
                        if (r_dmem_read) begin
                            r_load_data <= w_ext;
                        end
                    end else if (w_timeout) begin
                        r_dmem_read  <= 1'b0;
                        r_dmem_write <= 1'b0;
                        r_mem_err    <= 1'b1;
                        r_done       <= 1'b1;
                    end else if (r_cnt != {CNT_W{1'b1}}) begin
                        // Saturate so an unbounded wait never wraps.
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dmem_read  = r_dmem_read;
    assign dmem_write = r_dmem_write;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wmask = r_dmem_wmask;
    assign dmem_wdata = r_dmem_wdata;
    assign load_data  = r_load_data;
    assign mem_err    = r_mem_err;
    assign done       = r_done;
    assign stall      = w_stall;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit against a behavioural load/store model
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, is_load, is_store, trap_in;
    logic [31:0] addr_aligned, write_data, dmem_rdata;
    logic [1:0]  bit_shift;
    logic [2:0]  funct3;
    logic [3:0]  wmask, rmask;
    logic        dmem_resp;
    logic        dmem_read, dmem_write, stall, mem_err, done;
    logic [31:0] dmem_addr, dmem_wdata, load_data;
    logic [3:0]  dmem_wmask;

    mem_access_unit #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .is_load(is_load), .is_store(is_store),
        .trap_in(trap_in), .addr_aligned(addr_aligned), .bit_shift(bit_shift), .funct3(funct3),
        .wmask(wmask), .rmask(rmask), .write_data(write_data), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .stall(stall),
        .load_data(load_data), .mem_err(mem_err), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wm;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] model_ld = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] sh,
                                             input logic [31:0] rd);
        logic [31:0] w, b, h;
        w = rd >> (8 * sh);
        b = w % 256;
        h = w % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            3'b010:  return w;
            default: return 32'd0;
        endcase
    endfunction

    // Monitor: samples shortly after each rising edge, well away from the negedge drive point.
    initial begin
        int   acc_cnt;
        int   st_cnt;
        exp_t e;
        acc_cnt = 0;
        st_cnt  = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                acc_cnt = 0;
                st_cnt  = 0;
            end else begin
                if (stall) st_cnt++;
                if (dmem_read || dmem_write) begin
                    acc_cnt++;
                    if (q.size() == 0) begin
                        chk("unexpected_request", 64'(dmem_read | dmem_write), 64'd0);
                    end else begin
                        chk("dmem_rd_wr", {dmem_read, dmem_write}, {q[0].rd, q[0].wr});
                        chk("dmem_addr", dmem_addr, q[0].addr);
                        chk("dmem_wmask", dmem_wmask, q[0].wm);
                        chk("dmem_wdata", dmem_wdata, q[0].wdata);
                    end
                end
                if (done) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 64'(done), 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("load_data", load_data, e.ld);
                        chk("mem_err", mem_err, e.err);
                        chk("access_cycles", acc_cnt, e.cyc);
                        chk("stall_cycles", st_cnt, e.cyc);
                        chk("done_stall_low", stall, 1'b0);
                        chk("done_req_low", {dmem_read, dmem_write}, 2'b00);
                    end
                    acc_cnt = 0;
                    st_cnt  = 0;
                end
            end
        end
    end

    task automatic idle_inputs();
        req_valid    = 1'b0;
        is_load      = 1'($urandom);
        is_store     = 1'($urandom);
        trap_in      = 1'b0;
        addr_aligned = $urandom & 32'hFFFF_FFFC;
        bit_shift    = 2'($urandom);
        funct3       = 3'($urandom);
        wmask        = 4'($urandom);
        rmask        = 4'($urandom);
        write_data   = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        q.delete();
        model_ld = 32'd0;
    endtask

    task automatic access(input logic ld, input logic st, input logic [2:0] f3, input logic [1:0] sh,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input logic [3:0] wm, input logic [3:0] rm, input int delay,
                          input bit noresp);
        exp_t e;
        bit   got;
        e.rd    = ld;
        e.wr    = st;
        e.addr  = addr;
        e.wm    = st ? wm : 4'd0;
        e.wdata = wd << (8 * sh);
        e.err   = noresp;
        e.cyc   = noresp ? TO : delay + 1;
        if (ld && !noresp) model_ld = ref_load(f3, sh, rd);
        e.ld = model_ld;
        q.push_back(e);

        req_valid = 1'b1; is_load = ld; is_store = st; trap_in = 1'b0;
        addr_aligned = addr; bit_shift = sh; funct3 = f3; wmask = wm; rmask = rm;
        write_data = wd; dmem_resp = 1'b0;
        #1;
        chk("idle_req_stall", stall, 1'b1);
        @(negedge clk);
        idle_inputs();
        got = 0;
        for (int t = 0; t < 20; t++) begin
            if (done) begin
                got = 1;
                break;
            end
            if (!noresp && t == delay) begin
                dmem_resp  = 1'b1;
                dmem_rdata = rd;
            end else begin
                dmem_resp  = 1'b0;
                dmem_rdata = $urandom;
            end
            @(negedge clk);
        end
        if (!got) begin
            chk("done_within_budget", 64'(got), 64'd1);
            do_reset();
        end else begin
            // A response arriving while in DONE must be ignored.
            dmem_resp  = 1'($urandom);
            dmem_rdata = $urandom;
            @(negedge clk);
            dmem_resp = 1'b0;
        end
    endtask

    task automatic rand_access();
        int          op;
        logic        ld, st;
        logic [2:0]  f3;
        logic [1:0]  sh;
        logic [3:0]  m;
        op = $urandom_range(0, 8);
        ld = (op <= 4) || (op == 8);
        st = !ld;
        case (op)
            0, 1, 5: begin
                f3 = (op == 0) ? 3'b000 : (op == 1) ? 3'b100 : 3'b000;
                sh = 2'($urandom_range(0, 3));
                m  = 4'b0001 << sh;
            end
            2, 3, 6: begin
                f3 = (op == 2) ? 3'b001 : (op == 3) ? 3'b101 : 3'b001;
                sh = 2'(2 * $urandom_range(0, 1));
                m  = 4'b0011 << sh;
            end
            8: begin
                f3 = 3'b011; sh = 2'd0; m = 4'b1111;
            end
            default: begin
                f3 = 3'b010; sh = 2'd0; m = 4'b1111;
            end
        endcase
        access(ld, st, f3, sh, $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
               st ? m : 4'($urandom), ld ? m : 4'($urandom),
               $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    endtask

    initial begin
        idle_inputs();
        dmem_resp  = 1'b0;
        dmem_rdata = 32'd0;
        rst        = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_dmem", {dmem_read, dmem_write, dmem_addr, dmem_wmask, dmem_wdata}, 70'd0);
        chk("reset_status", {load_data, mem_err, done, stall}, 35'd0);
        rst = 1'b1;
        @(negedge clk);

        access(1, 0, 3'b010, 2'd0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 4'b0000, 4'b1111, 2, 0);
        access(0, 1, 3'b000, 2'd3, 32'h0000_2000, 32'h0000_00AB, 32'h0, 4'b1000, 4'b0000, 1, 0);
        access(1, 0, 3'b000, 2'd1, 32'h0000_3000, 32'h0, 32'h0000_8000, 4'b0000, 4'b0010, 0, 0);
        access(1, 0, 3'b100, 2'd1, 32'h0000_3000, 32'h0, 32'h0000_8000, 4'b0000, 4'b0010, 0, 0);
        access(1, 0, 3'b101, 2'd2, 32'h0000_4000, 32'h0, 32'hBEEF_0000, 4'b0000, 4'b1100, 1, 0);
        access(1, 0, 3'b001, 2'd2, 32'h0000_4000, 32'h0, 32'hBEEF_0000, 4'b0000, 4'b1100, 3, 0);
        access(1, 0, 3'b010, 2'd0, 32'h0000_5000, 32'h0, 32'h1234_5678, 4'b0000, 4'b1111, 0, 1);
        access(1, 0, 3'b010, 2'd0, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, 4'b0000, 4'b1111, 3, 0);

        req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; trap_in = 1'b1;
        #1;
        chk("trap_stall", stall, 1'b0);
        @(negedge clk);
        chk("trap_no_read", {dmem_read, done}, 2'b00);
        trap_in = 1'b0; is_load = 1'b0;
        #1;
        chk("nonmem_stall", stall, 1'b0);
        @(negedge clk);
        idle_inputs();

        q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_6000, wm: 4'd0, wdata: 32'd0,
                      ld: 32'd0, err: 1'b0, cyc: 0});
        req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; addr_aligned = 32'h0000_6000;
        bit_shift = 2'd0; funct3 = 3'b010; rmask = 4'b1111; write_data = 32'd0;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        q.delete();
        model_ld = 32'd0;
        chk("rst_mid_read_drop", {dmem_read, stall}, 2'b00);
        chk("rst_mid_status", {load_data, mem_err, done}, 34'd0);
        rst = 1'b1; dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_resp = 1'b0;
        chk("stray_resp_ignored", {dmem_read, done, load_data}, 34'd0);
        @(negedge clk);
        chk("stray_resp_no_done", done, 1'b0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                req_valid = 1'b1; is_load = 1'b0; is_store = 1'b0;
                #1;
                chk("rand_nonmem_stall", stall, 1'b0);
                @(negedge clk);
                idle_inputs();
            end
            rand_access();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
